// File: rtl/io_input_port_if.sv
// Producer handshake, CPU control strobes and FIFO flags of the input port.
// The tri-state data bus stays a plain port on the block itself.
interface io_input_port_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] iport;
  logic             iport_valid;
  logic             iport_ready;
  logic             c_gi;
  logic             c_gs;
  logic             empty;
  logic             full;

  // Driven by the producer and the CPU control unit.
  modport master (
    output iport, iport_valid, c_gi, c_gs,
    input  iport_ready, empty, full
  );

  // Driven by the input port block.
  modport slave (
    input  iport, iport_valid, c_gi, c_gs,
    output iport_ready, empty, full
  );
endinterface

// File: rtl/io_input_port.sv
// Input port: valid/ready byte producer into a small FIFO.
// The CPU reads the head (c_gi) or a status byte (c_gs) over a shared tri-state bus.
module io_input_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  io_input_port_if.slave   port,
  output wire  [WIDTH-1:0] data_bus
);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [CNTW-1:0]  count;
  logic             underflow;

  logic             is_empty;
  logic             is_full;
  logic             push;
  logic             pop;
  logic             pop_empty;
  logic [2:0]       cnt_field;
  logic [CNTW+2:0]  cnt_ext;
  logic [WIDTH-1:0] status_byte;
  logic [WIDTH-1:0] bus_value;
  logic             bus_drive;

  // Flags come from the registered count only, so they never glitch.
  assign is_empty = (count == '0);
  assign is_full  = (count == CNTW'(DEPTH));

  assign port.empty       = is_empty;
  assign port.full        = is_full;
  assign port.iport_ready = !is_full && reset;

  assign push      = port.iport_valid && port.iport_ready;
  assign pop       = port.c_gi && !is_empty;
  assign pop_empty = port.c_gi && is_empty;

  // The status count field is three bits; deeper FIFOs saturate at 7.
  always_comb begin
    cnt_ext   = {3'b000, count};
    cnt_field = cnt_ext[2:0];
    if (cnt_ext > (CNTW + 3)'(7)) begin
      cnt_field = 3'b111;
    end
  end

  always_comb begin
    status_byte      = '0;
    status_byte[7]   = underflow;
    status_byte[6]   = is_full;
    status_byte[5]   = is_empty;
    status_byte[2:0] = cnt_field;
  end

  // c_gi wins the bus over c_gs; an empty read returns zero.
  always_comb begin
    bus_value = '0;
    bus_drive = 1'b0;
    if (port.c_gi) begin
      bus_drive = 1'b1;
      if (!is_empty) begin
        bus_value = mem[rd_ptr];
      end
    end else if (port.c_gs) begin
      bus_drive = 1'b1;
      bus_value = status_byte;
    end
  end

  assign data_bus = bus_drive ? bus_value : {WIDTH{1'bz}};

  // NOTE: storage is not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= port.iport;
    end
  end

  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A same-edge underflow overrides the clear from c_gs.
      if (pop_empty) begin
        underflow <= 1'b1;
      end else if (port.c_gs) begin
        underflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port: drivers queue expected bus bytes,
// a negedge monitor compares them whenever c_gi or c_gs drives the bus.
module tb_io_input_port;
  logic       clk;
  logic       reset;
  wire  [7:0] data_bus;

  io_input_port_if #(.WIDTH(8)) port ();

  io_input_port #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .port     (port.slave),
    .data_bus (data_bus)
  );

  int         n_vec;
  int         n_bad;
  logic [7:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one expected byte per cycle that the bus is driven.
  always @(negedge clk) begin
    if (port.c_gi || port.c_gs) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL bus_unexpected: got %02h expected no read", data_bus);
      end else begin
        check("bus", data_bus, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int waited;
    port.iport       = b;
    port.iport_valid = 1'b1;
    waited = 0;
    while (!port.iport_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!port.iport_ready) begin
      check("ready_timeout", {7'd0, port.iport_ready}, 8'h01);
    end
    tick();
    port.iport_valid = 1'b0;
  endtask

  task automatic read_gi(input logic [7:0] exp);
    exp_q.push_back(exp);
    port.c_gi = 1'b1;
    tick();
    port.c_gi = 1'b0;
  endtask

  task automatic read_gs(input logic [7:0] exp);
    exp_q.push_back(exp);
    port.c_gs = 1'b1;
    tick();
    port.c_gs = 1'b0;
  endtask

  task automatic check_flags(input string name, input logic rdy, input logic emp, input logic ful);
    check(name, {5'd0, port.iport_ready, port.empty, port.full}, {5'd0, rdy, emp, ful});
  endtask

  initial begin
    n_vec            = 0;
    n_bad            = 0;
    reset            = 1'b0;
    port.iport       = 8'h77;
    port.iport_valid = 1'b1;
    port.c_gi        = 1'b0;
    port.c_gs        = 1'b0;

    // 1. Held in reset with a valid producer: not ready, empty.
    repeat (3) tick();
    check_flags("reset_flags", 1'b0, 1'b1, 1'b0);
    port.iport_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_flags("release_flags", 1'b1, 1'b1, 1'b0);
    tick();
    read_gs(8'h20);

    // 2. Two bytes in, two out in order.
    push_byte(8'hA5);
    push_byte(8'h3C);
    read_gi(8'hA5);
    read_gi(8'h3C);
    check_flags("drained_flags", 1'b1, 1'b1, 1'b0);
    read_gs(8'h20);

    // 3. Fill to full with valid held; fifth byte waits for a pop.
    port.iport_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      port.iport = 8'(i);
      tick();
    end
    port.iport = 8'h05;
    check_flags("full_flags", 1'b0, 1'b0, 1'b1);
    read_gs(8'h44);
    check_flags("full_hold", 1'b0, 1'b0, 1'b1);
    read_gi(8'h01);
    check_flags("after_pop_full", 1'b1, 1'b0, 1'b0);
    tick();
    port.iport_valid = 1'b0;
    check_flags("refilled", 1'b0, 1'b0, 1'b1);
    read_gi(8'h02);
    read_gi(8'h03);
    read_gi(8'h04);
    read_gi(8'h05);
    check_flags("drain3_flags", 1'b1, 1'b1, 1'b0);

    // 4. Underflow is sticky; c_gs clears it unless c_gi underflows on the same edge.
    read_gi(8'h00);
    exp_q.push_back(8'h00);
    port.c_gi = 1'b1;
    port.c_gs = 1'b1;
    tick();
    port.c_gi = 1'b0;
    port.c_gs = 1'b0;
    read_gs(8'hA0);
    read_gs(8'h20);

    // 5. Two queued, then simultaneous push and pop for ten edges.
    push_byte(8'h11);
    push_byte(8'h22);
    for (int i = 0; i < 10; i++) begin
      port.iport       = 8'h30 + 8'(i);
      port.iport_valid = 1'b1;
      port.c_gi        = 1'b1;
      exp_q.push_back(i == 0 ? 8'h11 : (i == 1 ? 8'h22 : 8'h30 + 8'(i - 2)));
      tick();
    end
    port.iport_valid = 1'b0;
    port.c_gi        = 1'b0;
    read_gs(8'h02);
    read_gi(8'h38);
    read_gi(8'h39);
    read_gs(8'h20);

    // 6. Async reset mid-cycle discards buffered bytes at once.
    push_byte(8'hE1);
    push_byte(8'hE2);
    push_byte(8'hE3);
    read_gs(8'h03);
    #2;
    reset = 1'b0;
    #1;
    check_flags("async_reset", 1'b0, 1'b1, 1'b0);
    exp_q.push_back(8'h20);
    port.c_gs = 1'b1;
    tick();
    port.c_gs = 1'b0;
    reset = 1'b1;
    tick();
    read_gi(8'h00);
    read_gs(8'hA0);
    read_gs(8'h20);

    tick();
    check("scoreboard_left", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
